// File: rtl/obi_write_arbiter.sv
`default_nettype none
// ==== obi_write_arbiter: round-robin share of one OBI master port between N memory nodes ====
// Revision: 1.0 - initial release
package obi_write_arbiter_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_write_arbiter
  import obi_write_arbiter_pkg::*;
#(
  parameter int N_MASTERS       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  obi_req_t  [N_MASTERS-1:0] masters_req_i,
  output obi_resp_t [N_MASTERS-1:0] masters_resp_o,
  output obi_req_t                  slave_req_o,
  input  obi_resp_t                 slave_resp_i,
  output logic                      err_o
);

  localparam int IW = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_MASTERS - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic [IW-1:0] prio;
  logic          locked;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] id_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [IW-1:0] rr_sel;
  logic [IW-1:0] sel;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          pop;

  // Scan from the priority pointer, wrapping at N_MASTERS (need not be a power of two).
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    logic          found;
    rr_sel   = prio;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = int'(prio) + k;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      cand_idx = IW'(cand);
      if (!found && masters_req_i[cand_idx].req) begin
        rr_sel = cand_idx;
        found  = 1'b1;
      end
    end
  end

  assign sel    = locked ? lock_idx : rr_sel;
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign head   = id_fifo[rd_ptr];
  assign accept = slave_req_o.req & slave_resp_i.gnt;
  assign pop    = slave_resp_i.rvalid & ~empty;

  always_comb begin
    slave_req_o     = masters_req_i[sel];
    slave_req_o.req = masters_req_i[sel].req & ~full;
  end

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_resp
    assign masters_resp_o[g].gnt    = accept & (sel == IW'(g));
    assign masters_resp_o[g].rvalid = pop & (head == IW'(g));
    assign masters_resp_o[g].rdata  = slave_resp_i.rdata;
  end

  always_ff @(posedge clk_i) begin
    if (accept) id_fifo[wr_ptr] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      prio     <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_o    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        prio   <= (sel == LAST_IDX) ? '0 : sel + IW'(1);
        locked <= 1'b0;
      end else if (slave_req_o.req && !locked) begin
        // Pending but not granted: freeze selection so the request stays stable.
        locked   <= 1'b1;
        lock_idx <= sel;
      end else if (locked && !masters_req_i[lock_idx].req) begin
        locked <= 1'b0;
      end

      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);

      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (slave_resp_i.rvalid && empty) err_o <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_write_arbiter.sv
`default_nettype none
// ==== tb_obi_write_arbiter: directed plan plus random traffic against a queue-based model ====
// Revision: 1.0 - initial release
module tb_obi_write_arbiter;
  import obi_write_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int MO = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clr = 1'b0;
  obi_req_t  [N-1:0]   mreq;
  obi_resp_t [N-1:0]   mresp;
  obi_req_t            sreq;
  obi_resp_t           sresp;
  logic                err;

  always #5 clk = ~clk;

  obi_write_arbiter #(.N_MASTERS(N), .MAX_OUTSTANDING(MO)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clr_i          (clr),
    .masters_req_i  (mreq),
    .masters_resp_o (mresp),
    .slave_req_o    (sreq),
    .slave_resp_i   (sresp),
    .err_o          (err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: priority pointer, lock, and an in-order queue of issuing node IDs.
  int prio_m = 0;
  bit locked_m = 0;
  int lock_m = 0;
  int q[$];
  bit err_m = 0;
  int n_prio, n_lock;
  bit n_locked, n_err;
  int nq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] gvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mresp[i].gnt;
    return v;
  endfunction

  function automatic logic [N-1:0] rvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mresp[i].rvalid;
    return v;
  endfunction

  function automatic int model_sel();
    if (locked_m) return lock_m;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (prio_m + k) % N;
      if (mreq[c].req) return c;
    end
    return prio_m;
  endfunction

  function automatic obi_req_t mk(input logic [31:0] a);
    obi_req_t r;
    r.req   = 1'b1;
    r.we    = 1'b1;
    r.be    = 4'(1 + $urandom_range(0, 14));
    r.addr  = a;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic idle();
    mreq  = '0;
    sresp = '0;
  endtask

  task automatic all_req(input logic [31:0] base);
    for (int i = 0; i < N; i++) mreq[i] = mk(base + 32'(i * 16));
  endtask

  // Compare every output against the model mid-cycle and stage the model's next state.
  task automatic check_now();
    int           sel;
    bit           full, acc, pop;
    obi_req_t     e;
    logic [N-1:0] eg, er;
    @(negedge clk);
    sel   = model_sel();
    full  = (q.size() == MO);
    e     = mreq[sel];
    e.req = mreq[sel].req & !full;
    acc   = e.req & sresp.gnt;
    pop   = sresp.rvalid && (q.size() > 0);
    eg    = acc ? (N'(1) << sel) : '0;
    er    = pop ? (N'(1) << q[0]) : '0;
    chk("slave_req", sreq, e);
    chk("gnt_vec", gvec(), eg);
    chk("rvalid_vec", rvec(), er);
    chk("rdata_fwd", mresp[$urandom_range(0, N - 1)].rdata, sresp.rdata);
    chk("err", err, err_m);

    nq = q; n_prio = prio_m; n_locked = locked_m; n_lock = lock_m; n_err = err_m;
    if (!rst_n || clr) begin
      nq.delete();
      n_prio = 0; n_locked = 0; n_lock = 0; n_err = 0;
    end else begin
      if (sresp.rvalid) begin
        if (q.size() == 0) n_err = 1;
        else void'(nq.pop_front());
      end
      if (acc) begin
        nq.push_back(sel);
        n_prio   = (sel + 1) % N;
        n_locked = 0;
      end else if (e.req && !locked_m) begin
        n_locked = 1;
        n_lock   = sel;
      end else if (locked_m && !mreq[lock_m].req) begin
        n_locked = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    q = nq; prio_m = n_prio; locked_m = n_locked; lock_m = n_lock; err_m = n_err;
    #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_now(); chk("rst_err", err, 1'b0); chk("rst_rvalid", rvec(), 4'b0000); adv();
    rst_n = 1'b1;

    // Single node: node 2, immediate grant, response two cycles later
    mreq[2] = mk(32'h1000); sresp.gnt = 1'b1;
    check_now(); chk("t1_gnt", gvec(), 4'b0100); chk("t1_addr", sreq.addr, 32'h1000); adv();
    idle();
    check_now(); chk("t1_quiet", gvec() | rvec(), 4'b0000); adv();
    sresp.rvalid = 1'b1; sresp.rdata = 32'hCAFE0002;
    check_now(); chk("t1_rvalid", rvec(), 4'b0100); chk("t1_rdata", mresp[2].rdata, 32'hCAFE0002); adv();
    idle();
    check_now(); chk("t1_once", rvec(), 4'b0000); adv();
    all_req(32'h1100); sresp.gnt = 1'b1;
    check_now(); chk("t1_prio3", gvec(), 4'b1000); adv();
    idle(); sresp.rvalid = 1'b1;
    check_now(); chk("t1_drain", rvec(), 4'b1000); adv();

    // Fairness: everyone requesting, gnt held high
    for (int k = 0; k < 8; k++) begin
      idle(); all_req(32'h2000 + 32'(k * 256)); sresp.gnt = 1'b1;
      sresp.rvalid = (k > 0); sresp.rdata = $urandom;
      check_now();
      chk("fair_gnt", gvec(), 4'b0001 << (k % 4));
      if (k > 0) chk("fair_rv", rvec(), 4'b0001 << ((k - 1) % 4));
      adv();
    end
    idle(); sresp.rvalid = 1'b1;
    check_now(); chk("fair_last_rv", rvec(), 4'b1000); adv();

    // Lock: nodes 1 and 3, grant withheld five cycles
    idle(); mreq[1] = mk(32'h2100); mreq[3] = mk(32'h2300);
    for (int k = 0; k < 6; k++) begin
      sresp.gnt = (k == 5);
      check_now();
      chk("lock_addr", sreq.addr, 32'h2100);
      chk("lock_gnt", gvec(), (k == 5) ? 4'b0010 : 4'b0000);
      adv();
    end
    mreq[1].req = 1'b0;
    check_now(); chk("lock_next", gvec(), 4'b1000); adv();
    idle(); sresp.rvalid = 1'b1;
    check_now(); chk("lock_rv1", rvec(), 4'b0010); adv();
    check_now(); chk("lock_rv3", rvec(), 4'b1000); adv();

    // Full: four accepts with no response, fifth held off
    idle(); mreq[0] = mk(32'h3000); sresp.gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_now(); chk("full_fill", gvec(), 4'b0001); adv();
    end
    check_now(); chk("full_req", sreq.req, 1'b0); chk("full_nogrant", gvec(), 4'b0000); adv();
    sresp.rvalid = 1'b1;
    check_now(); chk("full_req2", sreq.req, 1'b0); chk("full_rv", rvec(), 4'b0001); adv();
    sresp.rvalid = 1'b0;
    check_now(); chk("full_resume", gvec(), 4'b0001); adv();
    idle(); sresp.rvalid = 1'b1;
    repeat (2) begin check_now(); chk("full_drain", rvec(), 4'b0001); adv(); end

    // Simultaneous accept and response at count 2
    mreq[2] = mk(32'h4000); sresp.gnt = 1'b1;
    check_now(); chk("sim_gnt", gvec(), 4'b0100); chk("sim_rv", rvec(), 4'b0001); adv();
    idle(); sresp.rvalid = 1'b1;
    check_now(); chk("sim_rv_a", rvec(), 4'b0001); adv();
    check_now(); chk("sim_rv_b", rvec(), 4'b0100); adv();
    // Unexpected response: routed nowhere, error rises
    check_now(); chk("err_norv", rvec(), 4'b0000); adv();
    idle();
    check_now(); chk("err_set", err, 1'b1); adv();

    // Clear for one cycle
    clr = 1'b1;
    check_now(); adv();
    clr = 1'b0; all_req(32'h5000); sresp.gnt = 1'b1;
    check_now(); chk("clr_err", err, 1'b0); chk("clr_prio0", gvec(), 4'b0001); adv();
    check_now(); adv();

    // Reset for one cycle with transactions pending
    idle(); rst_n = 1'b0;
    check_now(); adv();
    rst_n = 1'b1; sresp.rvalid = 1'b1;
    check_now(); chk("rst_stale_rv", rvec(), 4'b0000); adv();
    idle(); all_req(32'h6000); sresp.gnt = 1'b1;
    check_now(); chk("rst_err_set", err, 1'b1); chk("rst_prio0", gvec(), 4'b0001); adv();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        mreq[i] = mk($urandom);
        mreq[i].req = ($urandom_range(0, 1) == 1);
      end
      sresp.gnt    = ($urandom_range(0, 1) == 1);
      sresp.rvalid = ($urandom_range(0, 9) < 4);
      sresp.rdata  = $urandom;
      clr   = ($urandom_range(0, 59) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      check_now(); adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/obi_write_arbiter.md
# obi_write_arbiter

Round-robin arbiter that shares one OBI memory master port between `N_MASTERS` CGRA memory nodes, e.g. the output memory nodes that push results to system memory. Each node sees a private OBI port; the arbiter selects one request per cycle and forwards it to the shared port. It returns `gnt` to the selected node and routes each response phase (`rvalid`/`rdata`) back to the node that issued the request. It sits between the memory-node array and the system bus inside the CGRA top level.

## Interface
Parameters:
- `N_MASTERS`, 4: number of requesting nodes (≥2).
- `MAX_OUTSTANDING`, 4: accepted-but-unanswered transactions tracked (power of two, ≥1).

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `clr_i`  in  1  synchronous clear; same effect as reset.
- `masters_req_i`  in  obi_req_t[N_MASTERS]  per-node request (`req`, `we`, `be`, `addr`, `wdata`).
- `masters_resp_o`  out  obi_resp_t[N_MASTERS]  per-node response (`gnt`, `rvalid`, `rdata`).
- `slave_req_o`  out  obi_req_t  shared port request.
- `slave_resp_i`  in  obi_resp_t  shared port response.
- `err_o`  out  1  sticky: `rvalid` received with no outstanding transaction.

## Operation
- Index width `IW = max(1, $clog2(N_MASTERS))`. Registers:
  - `prio` (IW bits): highest-priority index.
  - `locked` (1 bit) and `lock_idx` (IW bits).
  - ID FIFO: `MAX_OUTSTANDING` entries of IW bits, with a count register.
  - `err_o`.
- Selection (combinational):
  - If `locked`, `sel = lock_idx`.
  - Otherwise `sel` is the first index with `req=1`, scanning `prio, prio+1, …` modulo `N_MASTERS`.
  - `any_req` means at least one node request is asserted.
- Request forwarding:
  - `slave_req_o` carries all fields of `masters_req_i[sel]`.
  - `slave_req_o.req = masters_req_i[sel].req & !fifo_full`.
- Grant:
  - `masters_resp_o[sel].gnt = slave_resp_i.gnt & slave_req_o.req`.
  - All other `gnt` outputs are 0.
- Accept is `slave_req_o.req & slave_resp_i.gnt`. On accept:
  - Push `sel` into the ID FIFO.
  - Set `prio = sel+1` modulo `N_MASTERS`.
  - Clear `locked`.
- Lock:
  - Set when `slave_req_o.req=1`, `gnt=0` and `locked=0`; `lock_idx = sel`.
  - While locked, selection does not move, which preserves OBI request stability until grant.
  - A locked node dropping `req` (protocol violation) clears `locked` on the next edge.
- Response routing:
  - On `slave_resp_i.rvalid` with the FIFO not empty, drive `masters_resp_o[head].rvalid=1` and `rdata=slave_resp_i.rdata`, then pop.
  - All other `rvalid` outputs are 0.
  - `rdata` is forwarded to every node unconditionally; only `rvalid` is qualified.
- Error: `rvalid` with an empty FIFO routes to no node and sets `err_o=1` until reset or `clr_i`.
- Full: with `MAX_OUTSTANDING` entries pending, `slave_req_o.req=0` and no grants are issued. Lock state is held.
- Simultaneous accept and `rvalid` in one cycle: push and pop both happen and the count is unchanged. When the FIFO is empty, the popped entry is never the one being pushed.
- Reset or `clr_i` mid-operation:
  - `prio=0`, `locked=0`, FIFO emptied, `err_o=0`.
  - Responses to transactions issued before the clear are treated as unexpected and set `err_o`.
  - Integrators assert `clr_i` only with the bus idle.

## Timing
- Values while `rst_ni=0` or `clr_i=1` (registers, and outputs derived from them): `slave_req_o.req` follows the selected node's `req` with no lock (FIFO empty), `err_o=0`, all `rvalid=0`. `gnt` is purely combinational from `slave_resp_i.gnt`.
- Request and grant path: zero-cycle combinational `masters_req_i → slave_req_o` and `slave_resp_i.gnt → masters_resp_o.gnt`. No added latency.
- Response path: zero-cycle combinational `slave_resp_i.rvalid/rdata → masters_resp_o`.
- Throughput: one accept per cycle when `gnt` is held high. With all nodes requesting, grants rotate 0,1,2,3,0,…
- Ordering: the shared slave must return responses in order, which the OBI protocol requires.

## Test plan
- Single node: node 2 requests `addr=0x1000`, slave grants immediately, `rvalid` two cycles later. Node 2 gets `gnt` in the same cycle, then `rvalid` exactly once. Other nodes see no `gnt`/`rvalid`. `prio` becomes 3.
- Fairness: all 4 nodes request continuously, `gnt` tied high for 8 cycles. Grant order is 0,1,2,3,0,1,2,3. Responses return to nodes in issue order.
- Lock: nodes 1 and 3 request, `gnt=0` for 5 cycles, then `gnt=1`. `slave_req_o.addr` stays node 1's for all 6 cycles. Node 1 is granted, then node 3 on the next cycle.
- Full: `MAX_OUTSTANDING=4`, 4 accepts with no `rvalid`. `slave_req_o.req=0` while the 5th request is pending. One `rvalid` arrives; the 5th is granted the following cycle.
- Simultaneous: accept and `rvalid` in the same cycle with count=2. Count stays 2 and the pop goes to the oldest ID.
- Error and clear: `rvalid` with an empty FIFO sets `err_o=1` with no node `rvalid`. Assert `clr_i` for one cycle: `err_o=0`, `prio=0`. Do the same check with `rst_ni=0` for one cycle mid-transaction.
